// File: rtl/flash_ch_pkg.sv
//==============================================================================
// Module      : flash_ch_pkg
// Description : Shared definitions for the NVM flash channel model. Holds the
//               ISPP sequencer state encoding, the Q5.11 verify thresholds,
//               default ISPP step/budget values and helpers shared between the
//               program controller and the channel-output packer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package flash_ch_pkg;

    // ISPP sequencer state enumeration (explicit 2-bit encoding)
    typedef logic [1:0] ispp_state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_PULSE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cell level as carried on the command bus (2 bits per cell)
    typedef logic [1:0] cell_level_t;

    // Verify thresholds, Q5.11 unsigned
    localparam logic [15:0] VERIFY_L1 = 16'd7680;   // 3.75 V
    localparam logic [15:0] VERIFY_L2 = 16'd5222;   // 2.55 V
    localparam logic [15:0] VERIFY_L3 = 16'd6451;   // 3.15 V

    // Default ISPP parameters
    localparam logic [15:0] ISPP_STEP_DEFAULT   = 16'd205;  // 0.1 V in Q5.11
    localparam int          ISPP_JITTER_DEFAULT = 6;
    localparam logic [7:0]  ISPP_MAX_PULSES_DEF = 8'd16;

    // Packs the result word consumed by the channel-output packer:
    // {final Vth, initial Vth with the two LSBs dropped, level}
    function automatic logic [31:0] pack_res_word(
        input logic [15:0] vth,
        input logic [15:0] init_vth,
        input cell_level_t level
    );
        return {vth, init_vth[15:2], level};
    endfunction

    // Three-operand unsigned add, clamped to 16'hFFFF on any overflow.
    // Two guard bits cover the worst case of all three operands at maximum.
    function automatic logic [15:0] sat16_add3(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] c
    );
        logic [17:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
        return (sum[17:16] != 2'b00) ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ispp_program_ctrl_if.sv
//==============================================================================
// Module      : ispp_program_ctrl_if
// Description : Command / result handshake bundle of the ISPP program
//               controller.
//               master : command source + result consumer
//               slave  : the program controller
//   cmd_valid/cmd_ready  command handshake
//   cmd_level[1:0]       target level (0 = erased)
//   cmd_vth[15:0]        starting erased Vth, Q5.11
//   res_valid/res_ready  result handshake
//   res_vth[15:0]        final Vth, Q5.11
//   res_pulses[7:0]      pulses applied
//   res_fail             verify never passed within the pulse budget
//   res_word[31:0]       packed result word
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ispp_program_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_level;
    logic [15:0] cmd_vth;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_vth;
    logic [7:0]  res_pulses;
    logic        res_fail;
    logic [31:0] res_word;

    modport master (
        output cmd_valid, cmd_level, cmd_vth, res_ready,
        input  cmd_ready, res_valid, res_vth, res_pulses, res_fail, res_word
    );

    modport slave (
        input  cmd_valid, cmd_level, cmd_vth, res_ready,
        output cmd_ready, res_valid, res_vth, res_pulses, res_fail, res_word
    );
endinterface

`default_nettype wire

// File: rtl/ispp_verify_lut.sv
//==============================================================================
// Module      : ispp_verify_lut
// Description : Combinational map from target cell level to its Q5.11 verify
//               threshold. Level 0 (erased) maps to 0 so any Vth passes.
//   level[1:0]       target level
//   threshold[15:0]  verify threshold, Q5.11 unsigned
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ispp_verify_lut
    import flash_ch_pkg::*;
(
    input  cell_level_t level,
    output logic [15:0] threshold
);

    always_comb begin
        threshold = 16'd0;
        case (level)
            2'd1:    threshold = VERIFY_L1;
            2'd2:    threshold = VERIFY_L2;
            2'd3:    threshold = VERIFY_L3;
            default: threshold = 16'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ispp_program_ctrl.sv
//==============================================================================
// Module      : ispp_program_ctrl
// Description : Incremental-step-pulse-programming sequencer. Accepts one
//               cell-write command, applies jittered program pulses and
//               verifies after each, finishing on verify pass or when the
//               pulse budget is exhausted.
//   clk        system clock
//   reset      asynchronous reset, active low
//   bus        command/result handshake bundle (slave side)
//   jitter_i   free-running RNG word; low JITTER_BITS added per pulse
//   busy       sequencer is not idle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ispp_program_ctrl
    import flash_ch_pkg::*;
#(
    parameter logic [15:0] STEP_BASE   = ISPP_STEP_DEFAULT,
    parameter int          JITTER_BITS = ISPP_JITTER_DEFAULT,
    parameter logic [7:0]  MAX_PULSES  = ISPP_MAX_PULSES_DEF
)(
    input  logic                clk,
    input  logic                reset,
    ispp_program_ctrl_if.slave  bus,
    input  logic [15:0]         jitter_i,
    output logic                busy
);

    ispp_state_t r_state;
    cell_level_t r_level;
    logic [15:0] r_vth;
    logic [15:0] r_init_vth;
    logic [7:0]  r_count;
    logic        r_fail;

    logic [15:0] w_threshold;
    logic [15:0] w_jitter;
    logic [15:0] w_vth_next;
    logic        w_pass;

    // Only the low JITTER_BITS of the RNG word contribute to the step
    generate
        if (JITTER_BITS >= 16) begin : g_jit_full
            assign w_jitter = jitter_i;
        end else begin : g_jit_part
            logic w_unused_jitter;
            assign w_jitter        = {{(16 - JITTER_BITS){1'b0}}, jitter_i[JITTER_BITS-1:0]};
            assign w_unused_jitter = &{1'b0, jitter_i[15:JITTER_BITS]};
        end
    endgenerate

    ispp_verify_lut u_verify_lut (
        .level     (r_level),
        .threshold (w_threshold)
    );

    assign w_pass     = (r_level == 2'd0) || (r_vth >= w_threshold);
    assign w_vth_next = sat16_add3(r_vth, STEP_BASE, w_jitter);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_level    <= 2'd0;
            r_vth      <= 16'd0;
            r_init_vth <= 16'd0;
            r_count    <= 8'd0;
            r_fail     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_level    <= bus.cmd_level;
                        r_vth      <= bus.cmd_vth;
                        r_init_vth <= bus.cmd_vth;
                        r_count    <= 8'd0;
                        r_fail     <= 1'b0;
                        r_state    <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    // Pass is tested before the budget so the last allowed
                    // pulse can still complete successfully.
                    if (w_pass) begin
                        r_fail  <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_count == MAX_PULSES) begin
                        r_fail  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    r_vth   <= w_vth_next;
                    r_count <= r_count + 8'd1;
                    r_state <= ST_VERIFY;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.res_valid  = (r_state == ST_DONE);
    assign bus.res_vth    = r_vth;
    assign bus.res_pulses = r_count;
    assign bus.res_fail   = r_fail;
    assign bus.res_word   = pack_res_word(r_vth, r_init_vth, r_level);
    assign busy           = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ispp_program_ctrl.sv
//==============================================================================
// Module      : tb_ispp_program_ctrl
// Description : Scoreboard bench for ispp_program_ctrl. Three instances cover
//               the default step, a large step with a 255-pulse budget and a
//               full-scale step that forces saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ispp_program_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  sel;
    logic        cmd_valid;
    logic        res_ready;
    logic [1:0]  cmd_level;
    logic [15:0] cmd_vth;
    logic [15:0] jitter;

    ispp_program_ctrl_if bus0 ();
    ispp_program_ctrl_if bus1 ();
    ispp_program_ctrl_if bus2 ();

    assign bus0.cmd_valid = cmd_valid && (sel == 2'd0);
    assign bus1.cmd_valid = cmd_valid && (sel == 2'd1);
    assign bus2.cmd_valid = cmd_valid && (sel == 2'd2);
    assign bus0.res_ready = res_ready && (sel == 2'd0);
    assign bus1.res_ready = res_ready && (sel == 2'd1);
    assign bus2.res_ready = res_ready && (sel == 2'd2);
    assign bus0.cmd_level = cmd_level;
    assign bus1.cmd_level = cmd_level;
    assign bus2.cmd_level = cmd_level;
    assign bus0.cmd_vth   = cmd_vth;
    assign bus1.cmd_vth   = cmd_vth;
    assign bus2.cmd_vth   = cmd_vth;

    logic busy0, busy1, busy2;

    ispp_program_ctrl #(.STEP_BASE(16'd205), .JITTER_BITS(6), .MAX_PULSES(8'd16)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .jitter_i(jitter), .busy(busy0));
    ispp_program_ctrl #(.STEP_BASE(16'h8000), .JITTER_BITS(6), .MAX_PULSES(8'd255)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .jitter_i(jitter), .busy(busy1));
    ispp_program_ctrl #(.STEP_BASE(16'hFFFF), .JITTER_BITS(6), .MAX_PULSES(8'd16)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .jitter_i(jitter), .busy(busy2));

    // Outputs of the currently selected instance
    logic        o_cmd_ready, o_res_valid, o_res_fail, o_busy;
    logic [15:0] o_res_vth;
    logic [7:0]  o_res_pulses;
    logic [31:0] o_res_word;

    always_comb begin
        o_cmd_ready  = bus0.cmd_ready;
        o_res_valid  = bus0.res_valid;
        o_res_fail   = bus0.res_fail;
        o_res_vth    = bus0.res_vth;
        o_res_pulses = bus0.res_pulses;
        o_res_word   = bus0.res_word;
        o_busy       = busy0;
        if (sel == 2'd1) begin
            o_cmd_ready  = bus1.cmd_ready;
            o_res_valid  = bus1.res_valid;
            o_res_fail   = bus1.res_fail;
            o_res_vth    = bus1.res_vth;
            o_res_pulses = bus1.res_pulses;
            o_res_word   = bus1.res_word;
            o_busy       = busy1;
        end else if (sel == 2'd2) begin
            o_cmd_ready  = bus2.cmd_ready;
            o_res_valid  = bus2.res_valid;
            o_res_fail   = bus2.res_fail;
            o_res_vth    = bus2.res_vth;
            o_res_pulses = bus2.res_pulses;
            o_res_word   = bus2.res_word;
            o_busy       = busy2;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  lvl;
        logic [15:0] vth0;
        logic [15:0] vth;
        logic [7:0]  pulses;
        logic        fail;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc;

    // Reference ISPP loop; jitter is held constant for a whole command
    function automatic exp_t model(input logic [1:0] lvl, input logic [15:0] vth,
                                   input logic [15:0] jit, input int stepv, input int maxp);
        exp_t e;
        int   v, thr, s;
        int   p;
        logic [5:0] j6;
        j6  = jit[5:0];
        thr = (lvl == 2'd1) ? 7680 : (lvl == 2'd2) ? 5222 : (lvl == 2'd3) ? 6451 : 0;
        v   = int'(vth);
        p   = 0;
        e.lvl  = lvl;
        e.vth0 = vth;
        e.fail = 1'b0;
        while (1) begin
            if (lvl == 2'd0 || v >= thr) begin
                e.fail = 1'b0;
                break;
            end
            if (p == maxp) begin
                e.fail = 1'b1;
                break;
            end
            s = v + stepv + int'(j6);
            v = (s > 65535) ? 65535 : s;
            p++;
        end
        e.vth    = v[15:0];
        e.pulses = p[7:0];
        return e;
    endfunction

    task automatic send(input logic [1:0] s, input logic [1:0] lvl,
                        input logic [15:0] vth, input logic [15:0] jit);
        int   stepv, maxp;
        logic accepted;
        stepv = (s == 2'd0) ? 205 : (s == 2'd1) ? 32768 : 65535;
        maxp  = (s == 2'd1) ? 255 : 16;
        sel       = s;
        jitter    = jit;
        cmd_level = lvl;
        cmd_vth   = vth;
        sb.push_back(model(lvl, vth, jit, stepv, maxp));
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (o_cmd_ready) begin
                step();
                acc_cyc  = cyc;
                accepted = 1'b1;
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        check("accept", accepted, 1'b1);
    endtask

    task automatic collect(input int hold);
        exp_t        e;
        logic        seen;
        logic [31:0] exp_word;
        logic [31:0] word0;
        logic [15:0] vth0;
        if (sb.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
            return;
        end
        e    = sb.pop_front();
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (o_res_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("res_valid_seen", seen, 1'b1);
        if (!seen) return;
        exp_word = {e.vth, e.vth0[15:2], e.lvl};
        check("latency",    cyc - acc_cyc, 1 + 2 * int'(e.pulses));
        check("res_vth",    o_res_vth, e.vth);
        check("res_pulses", o_res_pulses, e.pulses);
        check("res_fail",   o_res_fail, e.fail);
        check("res_word",   o_res_word, exp_word);
        check("done_ready", o_cmd_ready, 1'b0);
        check("done_busy",  o_busy, 1'b1);
        vth0  = o_res_vth;
        word0 = o_res_word;
        // Backpressure: result must hold and new commands must be refused
        res_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            cmd_level = 2'd0;
            step();
            check("hold_valid", o_res_valid, 1'b1);
            check("hold_vth",   o_res_vth, e.vth);
            check("hold_word",  o_res_word, exp_word);
            check("hold_ready", o_cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("post_valid", o_res_valid, 1'b0);
        check("post_ready", o_cmd_ready, 1'b1);
        check("post_busy",  o_busy, 1'b0);
    endtask

    initial begin
        sel       = 2'd0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_level = 2'd0;
        cmd_vth   = 16'd0;
        jitter    = 16'd0;

        // Reset state
        repeat (2) step();
        check("rst_valid",  bus0.res_valid, 1'b0);
        check("rst_vth",    bus0.res_vth, 16'd0);
        check("rst_pulses", bus0.res_pulses, 8'd0);
        check("rst_fail",   bus0.res_fail, 1'b0);
        check("rst_word",   bus0.res_word, 32'd0);
        check("rst_busy",   busy0, 1'b0);
        reset = 1'b1;
        step();
        check("rst_ready", bus0.cmd_ready, 1'b1);

        // Default-step instance
        send(2'd0, 2'd0, 16'd2867, 16'd0);      collect(0);
        send(2'd0, 2'd2, 16'd2867, 16'd0);      collect(0);
        send(2'd0, 2'd1, 16'd2867, 16'd0);      collect(0);
        send(2'd0, 2'd3, 16'd6000, 16'hFFFF);   collect(5);
        for (int r = 0; r < 4; r++) begin
            send(2'd0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 9000)),
                 16'($urandom));
            collect(r);
        end

        // Large step, 255-pulse budget
        send(2'd1, 2'd1, 16'h7000, 16'd0);      collect(0);
        send(2'd1, 2'd1, 16'h1000, 16'd0);      collect(0);
        send(2'd1, 2'd0, 16'hFFF0, 16'd0);      collect(0);

        // Full-scale step saturates
        send(2'd2, 2'd1, 16'h1000, 16'hFFFF);   collect(0);
        send(2'd2, 2'd2, 16'd1, 16'd0);         collect(1);

        // Reset in the middle of a pulse discards the command
        send(2'd0, 2'd1, 16'd2867, 16'd0);
        step();                                 // now in PULSE
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy",   busy0, 1'b0);
        check("mid_rst_valid",  bus0.res_valid, 1'b0);
        check("mid_rst_vth",    bus0.res_vth, 16'd0);
        check("mid_rst_pulses", bus0.res_pulses, 8'd0);
        check("mid_rst_fail",   bus0.res_fail, 1'b0);
        check("mid_rst_word",   bus0.res_word, 32'd0);
        step();
        check("mid_rst_busy2",  busy0, 1'b0);
        reset = 1'b1;
        sb.delete();
        step();
        check("rel_ready", bus0.cmd_ready, 1'b1);
        check("rel_valid", bus0.res_valid, 1'b0);
        send(2'd0, 2'd0, 16'd1234, 16'd0);      collect(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
